prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter ADDR_W, 16, PC/address width in bits.
REQ-002 Parameter INSTR_W, 16, instruction word width in bits.
REQ-003 Parameter DEPTH, 4, instruction queue entries; power of two, >= 2.
REQ-004 Parameter PC_STEP, 2, PC increment per fetched instruction.
REQ-005 Parameter RESET_PC, 0, fetch address after reset.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 mem_req  out  1  instruction read request to memory.
REQ-009 mem_addr  out  ADDR_W  read address; valid while mem_req=1.
REQ-010 mem_ack  in  1  memory completes the current request this cycle; mem_rdata valid.
REQ-011 mem_rdata  in  INSTR_W  read data, sampled only when mem_req=1 and mem_ack=1.
REQ-012 redirect  in  1  branch/jump: flush the queue and restart fetch at redirect_pc.
REQ-013 redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1.
REQ-014 instr_valid  out  1  queue head holds a valid instruction.
REQ-015 instr  out  INSTR_W  queue head instruction.
REQ-016 instr_pc  out  ADDR_W  address the head instruction was fetched from.
REQ-017 instr_ready  in  1  consumer accepts the head instruction this cycle.
REQ-018 dbg_count  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-019 dbg_state  out  2  FSM state: IDLE=0, REQ=1, DISCARD=2.

Function
REQ-020 State fetch_pc is the address of the next request to issue; it wraps modulo 2^ADDR_W.
REQ-021 mem_req SHALL be 1 exactly when state is REQ or DISCARD; all outputs are driven from registers, with no combinational path from inputs to outputs.
REQ-022 Entering REQ SHALL load mem_addr <= fetch_pc; mem_addr SHALL hold stable until the cycle after mem_ack.
REQ-023 At most one memory request is outstanding at any time.
REQ-024 IDLE -> REQ when occupancy < DEPTH; otherwise the FSM stays in IDLE.
REQ-025 In REQ, mem_ack without redirect SHALL push {mem_rdata, mem_addr} into the queue and set fetch_pc <= mem_addr + PC_STEP.
REQ-026 After that push, the FSM SHALL stay in REQ (mem_addr <= mem_addr + PC_STEP) when next occupancy < DEPTH, otherwise go to IDLE; this gives back-to-back fetches when acks are single-cycle.
REQ-027 Pop occurs when instr_valid=1, instr_ready=1 and redirect=0.
REQ-028 Push and pop in the same cycle leave occupancy unchanged.
REQ-029 Read and write pointers wrap modulo DEPTH.
REQ-030 instr_valid = (occupancy != 0).
REQ-031 Data and PC of a pushed entry SHALL appear at the queue output no earlier than the next cycle.
REQ-032 Redirect SHALL, in any state, clear occupancy to 0 and set fetch_pc <= redirect_pc; the same-cycle pop is ignored.
REQ-033 Redirect in IDLE SHALL go to REQ.
REQ-034 Redirect in REQ with mem_ack=1 SHALL drop mem_rdata and go to REQ, with mem_addr <= redirect_pc.
REQ-035 Redirect in REQ with mem_ack=0 SHALL go to DISCARD; mem_req and the old mem_addr are held.
REQ-036 In DISCARD, mem_ack SHALL drop mem_rdata and go to REQ with mem_addr <= fetch_pc.
REQ-037 Redirect during DISCARD SHALL update fetch_pc only and stay in DISCARD.
REQ-038 Instructions fetched before a redirect SHALL never appear on instr after it.

Reset
REQ-039 While rst=1, and immediately on its assertion, the block SHALL force: state IDLE; mem_req 0; mem_addr RESET_PC; fetch_pc RESET_PC; occupancy 0; instr_valid 0; instr 0; instr_pc 0; pointers 0.
REQ-040 Reset during an outstanding request abandons it; mem_ack arriving during or after reset without mem_req=1 SHALL be ignored.
REQ-041 The first request after reset release SHALL go out on the second rising edge (IDLE -> REQ).

Verification
REQ-042 Defaults; mem_ack tied 1, instr_ready 0 -> mem_addr 0x0000, 0x0002, 0x0004, 0x0006 on consecutive cycles; then mem_req=0, dbg_count=4, dbg_state=0.
REQ-043 Request at 0x0010 outstanding; redirect to 0x0100; ack 3 cycles later -> mem_addr stays 0x0010 until ack, dbg_state=2, no push; next request 0x0100; first instr_pc=0x0100.
REQ-044 Queue full with 4 entries; instr_ready=1 for one cycle, ack in that cycle -> pop of head 0x0000, then push of 0x0008; dbg_count returns to 4 with no overflow.
REQ-045 Redirect to 0xFFFE with acks every cycle -> request addresses 0xFFFE, 0x0000, 0x0002; instr_pc sequence the same.
REQ-046 rst pulsed mid-request with mem_addr 0x0004 and dbg_count 2 -> mem_req 0 and instr_valid 0 before the next clock edge; after release the first request is 0x0000.
REQ-047 Redirect and mem_ack in the same cycle in REQ, with instr_ready=1 and dbg_count=1 -> no pop, no push, dbg_count 0, next mem_addr = redirect_pc.

Source files
------------

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetch unit with a small fetch queue and redirect handling
//
// Purpose:
//   Issues sequential instruction reads to memory, one outstanding request at
//   a time, and buffers the returned words with their fetch addresses in a
//   DEPTH-entry queue for the consumer. A redirect flushes the queue and
//   restarts fetch at a new address; a read already in flight when the
//   redirect arrives is completed and its data dropped.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mem_req/mem_addr  read request and address to memory
//   mem_ack/mem_rdata memory completion and read data
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   instr_valid/instr/instr_pc/instr_ready  queue head and consumer handshake
//   dbg_count/dbg_state   queue occupancy and FSM state (IDLE=0, REQ=1, DISCARD=2)

module prefetch_unit #(
  parameter int          ADDR_W   = 16,
  parameter int          INSTR_W  = 16,
  parameter int          DEPTH    = 4,
  parameter int          PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     dbg_count,
  output logic [1:0]                 dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] START_PC   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetchState_e;

  fetchState_e        state, stateNext;
  logic [ADDR_W-1:0]  memAddrQ, memAddrNext;
  logic [ADDR_W-1:0]  fetchPc, fetchPcNext;
  logic [CNT_W-1:0]   count, countNext, countAfterPush;
  logic [PTR_W-1:0]   rdPtr, wrPtr;
  logic               doPush, doPop, flush;

  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0]  pcMem    [DEPTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath control
  always_comb begin
    stateNext   = state;
    memAddrNext = memAddrQ;
    fetchPcNext = fetchPc;
    doPush      = 1'b0;
    flush       = 1'b0;

    // A redirect cancels any same-cycle pop: the head belongs to the old stream.
    doPop = (count != '0) && instr_ready && !redirect;

    // Occupancy after this cycle if a push happens; decides whether to keep fetching.
    countAfterPush = count + CNT_W'(1) - CNT_W'(doPop);

    case (state)
      IDLE: begin
        if (redirect) begin
          flush       = 1'b1;
          fetchPcNext = redirect_pc;
          memAddrNext = redirect_pc;
          stateNext   = REQ;
        end else if (count < FULL_COUNT) begin
          memAddrNext = fetchPc;
          stateNext   = REQ;
        end
      end

      REQ: begin
        if (redirect) begin
          flush       = 1'b1;
          fetchPcNext = redirect_pc;
          if (mem_ack) begin
            // Read completes now; its data is stale, so start the new stream directly.
            memAddrNext = redirect_pc;
          end else begin
            // Read still in flight: keep the request up and throw its data away.
            stateNext = DISCARD;
          end
        end else if (mem_ack) begin
          doPush      = 1'b1;
          fetchPcNext = memAddrQ + STEP;
          if (countAfterPush < FULL_COUNT) begin
            memAddrNext = memAddrQ + STEP;
          end else begin
            stateNext = IDLE;
          end
        end
      end

      DISCARD: begin
        if (redirect) begin
          flush       = 1'b1;
          fetchPcNext = redirect_pc;
          if (mem_ack) begin
            memAddrNext = redirect_pc;
            stateNext   = REQ;
          end
        end else if (mem_ack) begin
          memAddrNext = fetchPc;
          stateNext   = REQ;
        end
      end

      default: stateNext = IDLE;
    endcase

    if (flush) begin
      countNext = '0;
    end else begin
      countNext = count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Address, queue storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memAddrQ <= START_PC;
      fetchPc  <= START_PC;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i] <= '0;
        pcMem[i]    <= '0;
      end
    end else begin
      memAddrQ <= memAddrNext;
      fetchPc  <= fetchPcNext;
      count    <= countNext;
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (doPush) begin
          instrMem[wrPtr] <= mem_rdata;
          pcMem[wrPtr]    <= memAddrQ;
          wrPtr           <= wrPtr + PTR_W'(1);
        end
        if (doPop) begin
          rdPtr <= rdPtr + PTR_W'(1);
        end
      end
    end
  end

  assign mem_req     = (state != IDLE);
  assign mem_addr    = memAddrQ;
  assign instr_valid = (count != '0);
  assign instr       = instrMem[rdPtr];
  assign instr_pc    = pcMem[rdPtr];
  assign dbg_count   = count;
  assign dbg_state   = state;

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - self-checking bench for prefetch_unit

module tb_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  dbg_count;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .dbg_count   (dbg_count),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: every address holds a word derived from the address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  assign mem_rdata = memWord(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetDut();
    rst         = 1'b1;
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        expReq;
    logic [15:0] expAddr;
    int          expCount;
    int          expState;
    logic [15:0] expHead;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ack, input logic ready, input logic redir,
                              input logic [15:0] rpc, input logic expReq,
                              input logic [15:0] expAddr, input int expCount,
                              input int expState, input logic [15:0] expHead);
    vec_t v;
    v.ack = ack; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.expReq = expReq; v.expAddr = expAddr; v.expCount = expCount;
    v.expState = expState; v.expHead = expHead;
    return v;
  endfunction

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  initial begin
    ent_t        q[$];
    ent_t        e;
    logic        txOpen;
    int          txEpoch;
    logic [15:0] txAddr;
    int          epoch;
    logic [15:0] expPc;
    logic        popNow;

    vectors     = 0;
    miscompares = 0;

    // ack, ready, redir, rpc | req, addr, count, state, head pc
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0004, 2, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0006, 3, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 4, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 4, 0, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 3, 0, 16'h0002));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0008, 3, 1, 16'h0002));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 4, 0, 16'h0002));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 3, 0, 16'h0004));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h000A, 2, 1, 16'h0006));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h000A, 1, 1, 16'h0008));
    vecs.push_back(mk(1, 1, 1, 16'h0200, 1, 16'h0200, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0202, 1, 1, 16'h0200));
    vecs.push_back(mk(1, 0, 1, 16'hFFFE, 1, 16'hFFFE, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 1, 16'hFFFE));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0002));
    vecs.push_back(mk(1, 0, 1, 16'h0010, 1, 16'h0010, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 1, 16'h0010, 0, 2, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0010, 0, 2, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0010, 0, 2, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0102, 1, 1, 16'h0100));
    vecs.push_back(mk(0, 0, 1, 16'h0300, 1, 16'h0102, 0, 2, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 16'h0400, 1, 16'h0102, 0, 2, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0400, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0402, 1, 1, 16'h0400));

    resetDut();

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      mem_ack     = vecs[i].ack;
      instr_ready = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mem_req", i), mem_req, vecs[i].expReq);
      if (vecs[i].expReq) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].expAddr);
      check($sformatf("v%0d_count", i), dbg_count, vecs[i].expCount);
      check($sformatf("v%0d_state", i), dbg_state, vecs[i].expState);
      check($sformatf("v%0d_valid", i), instr_valid, vecs[i].expCount != 0);
      if (vecs[i].expCount != 0) begin
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].expHead);
        check($sformatf("v%0d_instr", i), instr, memWord(vecs[i].expHead));
      end
    end
    mem_ack  = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;

    // Reset asserted mid-request: outputs must clear before the next edge.
    resetDut();
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_mem_addr", mem_addr, 16'h0004);
    check("mid_count", dbg_count, 2);
    @(negedge clk);
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_valid", instr_valid, 0);
    check("async_count", dbg_count, 0);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    check("hold_mem_req", mem_req, 0);
    check("hold_count", dbg_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_mem_req", mem_req, 1);
    check("rel_mem_addr", mem_addr, 16'h0000);
    @(posedge clk);
    #1;
    check("rel_count", dbg_count, 1);
    check("rel_instr_pc", instr_pc, 16'h0000);
    check("rel_instr", instr, memWord(16'h0000));

    // Randomised run against a transaction-level model: each memory read
    // belongs to the redirect epoch in which it was issued and only reads
    // of the current epoch may enter the queue, in program order.
    resetDut();
    q.delete();
    txOpen  = 1'b0;
    txEpoch = 0;
    txAddr  = 16'h0;
    epoch   = 0;
    expPc   = 16'h0000;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      check("r_count", dbg_count, q.size());
      check("r_valid", instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("r_instr_pc", instr_pc, q[0].pc);
        check("r_instr", instr, q[0].ins);
      end
      if (txOpen && !mem_req) check("r_req_dropped", mem_req, 1);
      if (mem_req) begin
        if (!txOpen) begin
          txOpen  = 1'b1;
          txEpoch = epoch;
          txAddr  = mem_addr;
        end else begin
          check("r_addr_stable", mem_addr, txAddr);
        end
      end

      mem_ack     = ($urandom_range(0, 99) < 60);
      instr_ready = ($urandom_range(0, 99) < 50);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = 16'($urandom) & 16'hFFFE;

      popNow = (q.size() != 0) && instr_ready && !redirect;
      if (popNow) void'(q.pop_front());
      if (mem_req && mem_ack) begin
        txOpen = 1'b0;
        if (!redirect && txEpoch == epoch) begin
          check("r_fetch_order", txAddr, expPc);
          if (q.size() >= 4) check("r_overflow", q.size(), 3);
          e.pc  = txAddr;
          e.ins = memWord(txAddr);
          q.push_back(e);
          expPc = expPc + 16'd2;
        end
      end
      if (redirect) begin
        epoch++;
        q.delete();
        expPc = redirect_pc;
      end
    end
    @(negedge clk);
    mem_ack  = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
